nway_cache_control: RTL and testbench
=====================================

// Module: nway_cache_control
// PURPOSE
//  Parametrised N-way write-back, write-allocate cache controller FSM.
//  Sits between the CPU-side mem_* handshake and the pmem_* cacheline port.
//  Drives way-indexed load/valid/dirty strobes and datapath muxes for an
//  external tag/data array. Adds explicit victim-way latching, a
//  writeback-then-fill sequence, PLRU update and optional perf counters.
// PARAMETERS
//  NUM_WAYS    4   associativity, power of 2, >=2
//  WAY_W       $clog2(NUM_WAYS)  way index width (derived, localparam)
//  PERF_CNT_W  32  width of each perf counter (CACHE_CTRL_PERF_EN only)
// PORTS
//  clk          in   1         clock
//  reset_n      in   1         synchronous reset, active low
//  mem_read     in   1         CPU read request, held until mem_resp
//  mem_write    in   1         CPU write request, held until mem_resp
//  mem_resp     out  1         one-cycle completion pulse to CPU
//  hit          in   1         array: any valid way tag-matches
//  hit_way      in   WAY_W     array: index of matching way
//  victim_way   in   WAY_W     array PLRU: replacement candidate
//  victim_valid in   1         valid bit of victim_way
//  victim_dirty in   1         dirty bit of victim_way
//  pmem_resp    in   1         memory completes current line transfer
//  pmem_read    out  1         line fill request, held until pmem_resp
//  pmem_write   out  1         line writeback request, held until pmem_resp
//  way_sel      out  WAY_W     way targeted by array strobes
//  load_data    out  1         write data array at way_sel
//  load_tag     out  1         write tag array at way_sel
//  set_valid    out  1         set valid[way_sel]
//  set_dirty    out  1         set dirty[way_sel]
//  clr_dirty    out  1         clear dirty[way_sel]
//  data_sel     out  1         0: CPU write data/byte-enables, 1: pmem line
//  addr_sel     out  1         0: CPU address, 1: {victim tag, set} writeback
//  plru_update  out  1         touch PLRU with way_sel
// BEHAVIOUR
//  - State and victim register flopped; outputs combinational from state+inputs.
//  - Reset (reset_n==0 at posedge): state<=IDLE, victim reg<=0; every output
//    is 0 in IDLE absent a request, so all outputs read 0 the cycle after reset.
//    Reset mid-WRITEBACK/FILL abandons the transfer; pmem_* drop after that edge.
//  - States (cache_ctrl_pkg::state_t): IDLE, COMPARE, WRITEBACK, FILL.
//  - IDLE: (mem_read|mem_write) -> COMPARE (array read latency 1).
//  - COMPARE, hit: mem_resp=1, way_sel=hit_way, plru_update=1; if write:
//    load_data=1, set_dirty=1, data_sel=0. -> IDLE. Hit latency: 2 cycles.
//  - COMPARE, miss: latch victim_way; valid&dirty -> WRITEBACK, else -> FILL.
//  - WRITEBACK: pmem_write=1, addr_sel=1, way_sel=latched; pmem_resp -> FILL.
//  - FILL: pmem_read=1, addr_sel=0, way_sel=latched; on pmem_resp: load_data,
//    load_tag, set_valid, clr_dirty, data_sel=1 -> COMPARE (re-lookup hits).
//  - pmem_resp ignored in IDLE/COMPARE. mem_read&mem_write both high: treated
//    as write; flagged by assertion. Request dropping before mem_resp is a
//    protocol violation; controller completes in-flight line transfer anyway.
//  - At most one of pmem_read/pmem_write high in any cycle.
// CONFIGURATION
//  CACHE_CTRL_PERF_EN defined: adds outputs hit_cnt, miss_cnt, wb_cnt
//  (PERF_CNT_W each): +1 on COMPARE hit, COMPARE miss, WRITEBACK entry;
//  cleared by reset, saturate at all-ones. Undefined: ports and logic absent,
//  FSM behaviour identical.
// STRUCTURE
//  cache_ctrl_pkg: state_t enum, data_sel/addr_sel enum constants.
//  Sub-module cache_ctrl_perf (counters), instantiated only under macro.
// TESTING
//  1 read hit: req, hit=1 hit_way=2 -> mem_resp at cycle 1, way_sel=2, plru_update.
//  2 write hit way 3 -> load_data, set_dirty, data_sel=0, way_sel=3, one mem_resp.
//  3 clean miss victim 1 -> FILL, pmem_read until pmem_resp after 5 cycles,
//    fill strobes way 1, COMPARE hit, mem_resp; total 8 cycles.
//  4 dirty miss victim 0 -> pmem_write+addr_sel=1 until pmem_resp, then FILL,
//    then mem_resp; pmem_read/pmem_write never overlap.
//  5 reset_n low mid-FILL -> next cycle all outputs 0, state IDLE.
//  6 PERF_EN: scenarios 1-4 -> hit_cnt=4, miss_cnt=2, wb_cnt=1.

Source files
------------

// File: rtl/cache_ctrl_pkg.sv
// rtl/cache_ctrl_pkg.sv - shared FSM state and datapath mux encodings for nway_cache_control
package cache_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COMPARE,
        WRITEBACK,
        FILL
    } state_t;

    typedef enum logic {
        DATA_SEL_CPU  = 1'b0,
        DATA_SEL_PMEM = 1'b1
    } data_sel_t;

    typedef enum logic {
        ADDR_SEL_CPU = 1'b0,
        ADDR_SEL_WB  = 1'b1
    } addr_sel_t;

endpackage

// File: rtl/nway_cache_control_if.sv
// rtl/nway_cache_control_if.sv - CPU, pmem and tag/data array signals of nway_cache_control
interface nway_cache_control_if #(
    parameter int NUM_WAYS = 4
);
    localparam int WAY_W = $clog2(NUM_WAYS);

    logic             mem_read;
    logic             mem_write;
    logic             mem_resp;
    logic             hit;
    logic [WAY_W-1:0] hit_way;
    logic [WAY_W-1:0] victim_way;
    logic             victim_valid;
    logic             victim_dirty;
    logic             pmem_resp;
    logic             pmem_read;
    logic             pmem_write;
    logic [WAY_W-1:0] way_sel;
    logic             load_data;
    logic             load_tag;
    logic             set_valid;
    logic             set_dirty;
    logic             clr_dirty;
    logic             data_sel;
    logic             addr_sel;
    logic             plru_update;

    // master is the controller; slave is the CPU/array/memory side
    modport master (
        input  mem_read, mem_write, hit, hit_way, victim_way, victim_valid,
               victim_dirty, pmem_resp,
        output mem_resp, pmem_read, pmem_write, way_sel, load_data, load_tag,
               set_valid, set_dirty, clr_dirty, data_sel, addr_sel, plru_update
    );

    modport slave (
        output mem_read, mem_write, hit, hit_way, victim_way, victim_valid,
               victim_dirty, pmem_resp,
        input  mem_resp, pmem_read, pmem_write, way_sel, load_data, load_tag,
               set_valid, set_dirty, clr_dirty, data_sel, addr_sel, plru_update
    );

endinterface

// File: rtl/cache_ctrl_perf.sv
// rtl/cache_ctrl_perf.sv - saturating hit/miss/writeback counters for nway_cache_control
module cache_ctrl_perf #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             hit_evt,
    input  logic             miss_evt,
    input  logic             wb_evt,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt,
    output logic [CNT_W-1:0] wb_cnt
);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
            wb_cnt   <= '0;
        end else begin
            // counters hold at all-ones rather than wrapping
            if (hit_evt && (hit_cnt != '1))
                hit_cnt <= hit_cnt + ONE;
            if (miss_evt && (miss_cnt != '1))
                miss_cnt <= miss_cnt + ONE;
            if (wb_evt && (wb_cnt != '1))
                wb_cnt <= wb_cnt + ONE;
        end
    end

endmodule

// File: rtl/nway_cache_control.sv
// rtl/nway_cache_control.sv - N-way write-back/write-allocate cache controller FSM
// Optional perf counters (hit_cnt, miss_cnt, wb_cnt) built when CACHE_CTRL_PERF_EN is defined.
module nway_cache_control
    import cache_ctrl_pkg::*;
#(
    parameter int NUM_WAYS = 4
`ifdef CACHE_CTRL_PERF_EN
    ,
    parameter int PERF_CNT_W = 32
`endif
) (
    input  logic clk,
    input  logic reset_n,
    nway_cache_control_if.master bus
`ifdef CACHE_CTRL_PERF_EN
    ,
    output logic [PERF_CNT_W-1:0] hit_cnt,
    output logic [PERF_CNT_W-1:0] miss_cnt,
    output logic [PERF_CNT_W-1:0] wb_cnt
`endif
);
    localparam int WAY_W = $clog2(NUM_WAYS);

    state_t           state;
    logic [WAY_W-1:0] victim_q;
    logic             req;
    logic             victim_wb;

    assign req       = bus.mem_read | bus.mem_write;
    assign victim_wb = bus.victim_valid & bus.victim_dirty;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            victim_q <= '0;
        end else begin
            case (state)
                IDLE:      if (req) state <= COMPARE;
                COMPARE: begin
                    if (bus.hit) begin
                        state <= IDLE;
                    end else begin
                        // the array's PLRU may move during the line transfer; keep our pick
                        victim_q <= bus.victim_way;
                        state    <= victim_wb ? WRITEBACK : FILL;
                    end
                end
                WRITEBACK: if (bus.pmem_resp) state <= FILL;
                FILL:      if (bus.pmem_resp) state <= COMPARE;
                default:   state <= IDLE;
            endcase
        end
    end

    always_comb begin
        bus.mem_resp    = 1'b0;
        bus.pmem_read   = 1'b0;
        bus.pmem_write  = 1'b0;
        bus.way_sel     = '0;
        bus.load_data   = 1'b0;
        bus.load_tag    = 1'b0;
        bus.set_valid   = 1'b0;
        bus.set_dirty   = 1'b0;
        bus.clr_dirty   = 1'b0;
        bus.data_sel    = DATA_SEL_CPU;
        bus.addr_sel    = ADDR_SEL_CPU;
        bus.plru_update = 1'b0;
        case (state)
            COMPARE: begin
                if (bus.hit) begin
                    bus.mem_resp    = 1'b1;
                    bus.way_sel     = bus.hit_way;
                    bus.plru_update = 1'b1;
                    // a simultaneous read+write request is served as a write
                    if (bus.mem_write) begin
                        bus.load_data = 1'b1;
                        bus.set_dirty = 1'b1;
                    end
                end
            end
            WRITEBACK: begin
                bus.pmem_write = 1'b1;
                bus.addr_sel   = ADDR_SEL_WB;
                bus.way_sel    = victim_q;
            end
            FILL: begin
                bus.pmem_read = 1'b1;
                bus.way_sel   = victim_q;
                if (bus.pmem_resp) begin
                    bus.load_data = 1'b1;
                    bus.load_tag  = 1'b1;
                    bus.set_valid = 1'b1;
                    bus.clr_dirty = 1'b1;
                    bus.data_sel  = DATA_SEL_PMEM;
                end
            end
            default: ;
        endcase
    end

`ifdef CACHE_CTRL_PERF_EN
    logic hit_evt;
    logic miss_evt;
    logic wb_evt;

    assign hit_evt  = (state == COMPARE) &  bus.hit;
    assign miss_evt = (state == COMPARE) & ~bus.hit;
    assign wb_evt   = miss_evt & victim_wb;

    cache_ctrl_perf #(
        .CNT_W (PERF_CNT_W)
    ) u_perf (
        .clk      (clk),
        .reset_n  (reset_n),
        .hit_evt  (hit_evt),
        .miss_evt (miss_evt),
        .wb_evt   (wb_evt),
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt),
        .wb_cnt   (wb_cnt)
    );
`endif

`ifndef SYNTHESIS
    both_req_a: assert property (@(posedge clk) disable iff (!reset_n)
        !(bus.mem_read && bus.mem_write));
`endif

endmodule

// File: tb/tb_nway_cache_control.sv
// tb/tb_nway_cache_control.sv - scoreboard bench for nway_cache_control with randomized transactions
module tb_nway_cache_control;
    localparam int NUM_WAYS = 4;
    localparam int WAY_W    = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    nway_cache_control_if #(.NUM_WAYS(NUM_WAYS)) bus ();

`ifdef CACHE_CTRL_PERF_EN
    logic [31:0] hit_cnt, miss_cnt, wb_cnt;
`endif

    nway_cache_control #(.NUM_WAYS(NUM_WAYS)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
`ifdef CACHE_CTRL_PERF_EN
        ,
        .hit_cnt (hit_cnt),
        .miss_cnt(miss_cnt),
        .wb_cnt  (wb_cnt)
`endif
    );

    typedef struct {
        bit wr;
        int way;
        int victim;
        int lat;
        int wb_cyc;
        int fill_cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   n_hit = 0, n_miss = 0, n_wb = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic logic [12:0] outs();
        return {bus.mem_resp, bus.pmem_read, bus.pmem_write, bus.way_sel, bus.load_data,
                bus.load_tag, bus.set_valid, bus.set_dirty, bus.clr_dirty, bus.data_sel,
                bus.addr_sel, bus.plru_update};
    endfunction

    // monitor: follows each request and compares against the front scoreboard entry
    int   cyc = 0, wbc = 0, flc = 0;
    bit   active = 0;
    exp_t e;
    always @(negedge clk) begin
        if (!reset_n) begin
            exp_q.delete();
            active = 0;
        end else if (!(bus.mem_read | bus.mem_write)) begin
            check("idle_outputs", 32'(outs()), 32'd0);
            active = 0;
        end else begin
            if (!active) begin
                active = 1; cyc = 0; wbc = 0; flc = 0;
            end else begin
                cyc++;
            end
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_request: no scoreboard entry at cycle %0d", cyc);
            end else begin
                e = exp_q[0];
                if (bus.pmem_read | bus.pmem_write)
                    check("pmem_overlap", 32'(bus.pmem_read & bus.pmem_write), 32'd0);
                if (bus.pmem_write) begin
                    wbc++;
                    check("wb_addr_sel", 32'(bus.addr_sel), 32'd1);
                    check("wb_way", 32'(bus.way_sel), 32'(e.victim));
                end
                if (bus.pmem_read) begin
                    flc++;
                    check("fill_addr_sel", 32'(bus.addr_sel), 32'd0);
                    check("fill_way", 32'(bus.way_sel), 32'(e.victim));
                end
                if (bus.load_tag)
                    check("fill_strobes", 32'({bus.load_data, bus.set_valid, bus.clr_dirty,
                          bus.data_sel, bus.pmem_resp, bus.set_dirty}), 32'b111110);
                if (bus.mem_resp) begin
                    check("resp_way", 32'(bus.way_sel), 32'(e.way));
                    check("resp_latency", 32'(cyc), 32'(e.lat));
                    check("resp_strobes", 32'({bus.plru_update, bus.load_data, bus.set_dirty,
                          bus.data_sel, bus.load_tag, bus.pmem_read, bus.pmem_write}),
                          32'({1'b1, e.wr, e.wr, 4'b0000}));
                    check("wb_cycles", 32'(wbc), 32'(e.wb_cyc));
                    check("fill_cycles", 32'(flc), 32'(e.fill_cyc));
                    void'(exp_q.pop_front());
                    active = 0;
                end
            end
        end
    end

    // drives one CPU request and plays the array and memory until mem_resp
    task automatic run_txn(input bit wr, input bit hit, input int hway, input int vway,
                           input bit vvalid, input bit vdirty, input int lwb, input int lfl);
        exp_t x;
        bit   wb, filled, done;
        int   pcnt;
        wb         = !hit && vvalid && vdirty;
        x.wr       = wr;
        x.way      = hit ? hway : vway;
        x.victim   = vway;
        x.wb_cyc   = wb ? lwb : 0;
        x.fill_cyc = hit ? 0 : lfl;
        x.lat      = hit ? 1 : 1 + x.wb_cyc + lfl + 1;
        exp_q.push_back(x);
        n_hit++;
        if (!hit) n_miss++;
        if (wb) n_wb++;
        filled = 0; done = 0; pcnt = 0;
        bus.mem_read     = !wr;
        bus.mem_write    = wr;
        bus.victim_way   = WAY_W'(vway);
        bus.victim_valid = vvalid;
        bus.victim_dirty = vdirty;
        for (int c = 0; c < 200 && !done; c++) begin
            bus.hit     = hit || filled;
            bus.hit_way = filled ? WAY_W'(vway) : WAY_W'(hway);
            if (c >= 2 && !filled) bus.victim_way = WAY_W'($urandom_range(0, NUM_WAYS - 1));
            if (bus.pmem_read | bus.pmem_write)
                bus.pmem_resp = (pcnt + 1 >= (bus.pmem_write ? lwb : lfl));
            else
                bus.pmem_resp = 1'b0;
            @(negedge clk);
            if (bus.mem_resp) done = 1;
            if (bus.load_tag) filled = 1;
            if (bus.pmem_resp) pcnt = 0;
            else if (bus.pmem_read | bus.pmem_write) pcnt++;
            @(posedge clk); #1;
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL txn_timeout: no mem_resp within 200 cycles (wr=%0d hit=%0d)", wr, hit);
            exp_q.delete();
        end
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.hit       = 1'b0;
        bus.pmem_resp = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        bus.mem_read = 0; bus.mem_write = 0; bus.hit = 0; bus.hit_way = '0;
        bus.victim_way = '0; bus.victim_valid = 0; bus.victim_dirty = 0; bus.pmem_resp = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 32'(outs()), 32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // clean miss interrupted by reset while the fill is outstanding
        exp_q.push_back('{wr: 0, way: 1, victim: 1, lat: 0, wb_cyc: 0, fill_cyc: 0});
        bus.mem_read = 1; bus.victim_way = 2'd1; bus.victim_valid = 0;
        repeat (2) @(posedge clk);
        #1;
        check("pre_reset_fill", 32'(bus.pmem_read), 32'd1);
        @(posedge clk); #1;
        reset_n = 1'b0; bus.mem_read = 0;
        @(posedge clk); #1;
        check("reset_mid_fill_outputs", 32'(outs()), 32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        run_txn(0, 1, 2, 0, 0, 0, 1, 1);
        run_txn(1, 1, 3, 0, 0, 0, 1, 1);
        run_txn(0, 0, 0, 1, 1, 0, 1, 5);
        run_txn(0, 0, 0, 0, 1, 1, 4, 3);
`ifdef CACHE_CTRL_PERF_EN
        check("perf_hit_directed", hit_cnt, 32'd4);
        check("perf_miss_directed", miss_cnt, 32'd2);
        check("perf_wb_directed", wb_cnt, 32'd1);
`endif

        for (int i = 0; i < 40; i++) begin
            run_txn(1'($urandom_range(0, 1)), $urandom_range(0, 2) != 0,
                    $urandom_range(0, NUM_WAYS - 1), $urandom_range(0, NUM_WAYS - 1),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    $urandom_range(1, 6), $urandom_range(1, 6));
        end

        repeat (2) @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
`ifdef CACHE_CTRL_PERF_EN
        check("perf_hit_total", hit_cnt, 32'(n_hit));
        check("perf_miss_total", miss_cnt, 32'(n_miss));
        check("perf_wb_total", wb_cnt, 32'(n_wb));
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
